// File: rtl/uart_multi_xcvr.sv
// UART transceiver: TX serialises an NBYTES-character command word, most-significant character first;
// RX is fully independent and strobes each received character with its parity/framing status.
module uart_multi_xcvr #(
  parameter int DATA_W       = 8,
  parameter int NBYTES       = 2,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY       = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NBYTES*DATA_W-1:0] cmd_in,
  input  logic                     cmd_vld,
  output logic                     cmd_rdy,
  output logic                     tx,
  input  logic                     rx,
  output logic [DATA_W-1:0]        read_data,
  output logic                     read_vld,
  output logic                     parity_err,
  output logic                     frame_err
);
  localparam int KW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_W);
  localparam int CW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int SW = NBYTES * DATA_W;
  localparam logic [KW-1:0] K_LAST = KW'(CLKS_PER_BIT - 1);
  localparam logic [KW-1:0] K_HALF = KW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_W - 1);
  localparam logic [CW-1:0] C_LAST = CW'(NBYTES - 1);

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PAR, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP, RX_WAIT_HIGH} rx_state_t;

  // Parity bit that makes data+parity odd (PARITY=1) or even (PARITY=2).
  function automatic logic f_par_bit(input logic [DATA_W-1:0] d);
    return (PARITY == 2) ? ^d : ~^d;
  endfunction

  tx_state_t        r_tx_state, w_tx_state;
  logic             r_tx, w_tx;
  logic [KW-1:0]    r_tx_clk, w_tx_clk;
  logic [BW-1:0]    r_tx_bit, w_tx_bit;
  logic [CW-1:0]    r_tx_chr, w_tx_chr;
  logic [SW-1:0]    r_tx_shift, w_tx_shift;
  logic [DATA_W-1:0] r_tx_dsr, w_tx_dsr;
  logic [DATA_W-1:0] w_tx_cur;
  logic             w_tx_tick;

  assign w_tx_cur  = r_tx_shift[SW-1 -: DATA_W];
  assign w_tx_tick = (r_tx_clk == '0);
  assign cmd_rdy   = (r_tx_state == TX_IDLE);
  assign tx        = r_tx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_state <= TX_IDLE;
      r_tx       <= 1'b1;
      r_tx_clk   <= '0;
      r_tx_bit   <= '0;
      r_tx_chr   <= '0;
    end else begin
      r_tx_state <= w_tx_state;
      r_tx       <= w_tx;
      r_tx_clk   <= w_tx_clk;
      r_tx_bit   <= w_tx_bit;
      r_tx_chr   <= w_tx_chr;
    end
  end

  always_ff @(posedge clk) begin
    r_tx_shift <= w_tx_shift;
    r_tx_dsr   <= w_tx_dsr;
  end

  always_comb begin
    w_tx_state = r_tx_state;
    w_tx       = r_tx;
    w_tx_clk   = r_tx_clk;
    w_tx_bit   = r_tx_bit;
    w_tx_chr   = r_tx_chr;
    w_tx_shift = r_tx_shift;
    w_tx_dsr   = r_tx_dsr;
    case (r_tx_state)
      TX_IDLE: begin
        w_tx = 1'b1;
        if (cmd_vld) begin
          w_tx_state = TX_START;
          w_tx       = 1'b0;
          w_tx_clk   = K_LAST;
          w_tx_chr   = '0;
          w_tx_shift = cmd_in;
        end
      end
      default: begin
        if (!w_tx_tick) begin
          w_tx_clk = r_tx_clk - KW'(1);
        end else begin
          w_tx_clk = K_LAST;
          case (r_tx_state)
            TX_START: begin
              w_tx_state = TX_DATA;
              w_tx       = w_tx_cur[0];
              w_tx_dsr   = w_tx_cur >> 1;
              w_tx_bit   = '0;
            end
            TX_DATA: begin
              if (r_tx_bit == B_LAST) begin
                if (PARITY != 0) begin
                  w_tx_state = TX_PAR;
                  w_tx       = f_par_bit(w_tx_cur);
                end else begin
                  w_tx_state = TX_STOP;
                  w_tx       = 1'b1;
                end
              end else begin
                w_tx_bit = r_tx_bit + BW'(1);
                w_tx     = r_tx_dsr[0];
                w_tx_dsr = r_tx_dsr >> 1;
              end
            end
            TX_PAR: begin
              w_tx_state = TX_STOP;
              w_tx       = 1'b1;
            end
            default: begin
              // End of stop bit: next character starts immediately, no idle gap.
              if (r_tx_chr == C_LAST) begin
                w_tx_state = TX_IDLE;
                w_tx       = 1'b1;
              end else begin
                w_tx_state = TX_START;
                w_tx       = 1'b0;
                w_tx_chr   = r_tx_chr + CW'(1);
                w_tx_shift = r_tx_shift << DATA_W;
              end
            end
          endcase
        end
      end
    endcase
  end

  logic             r_rx_p0, r_rx_p1;
  logic             w_rx;
  rx_state_t        r_rx_state, w_rx_state;
  logic [KW-1:0]    r_rx_clk, w_rx_clk;
  logic [BW-1:0]    r_rx_bit, w_rx_bit;
  logic [DATA_W-1:0] r_rx_sr, w_rx_sr;
  logic             r_rx_par, w_rx_par;
  logic [DATA_W-1:0] r_read_data, w_read_data;
  logic             r_read_vld, w_read_vld;
  logic             r_parity_err, w_parity_err;
  logic             r_frame_err, w_frame_err;
  logic             w_rx_tick;

  assign w_rx       = r_rx_p1;
  assign w_rx_tick  = (r_rx_clk == '0);
  assign read_data  = r_read_data;
  assign read_vld   = r_read_vld;
  assign parity_err = r_parity_err;
  assign frame_err  = r_frame_err;

  // Synchroniser stage boundary: rx -> p0 -> p1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_p0      <= 1'b1;
      r_rx_p1      <= 1'b1;
      r_rx_state   <= RX_IDLE;
      r_rx_clk     <= '0;
      r_rx_bit     <= '0;
      r_read_data  <= '0;
      r_read_vld   <= 1'b0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_rx_p0      <= rx;
      r_rx_p1      <= r_rx_p0;
      r_rx_state   <= w_rx_state;
      r_rx_clk     <= w_rx_clk;
      r_rx_bit     <= w_rx_bit;
      r_read_data  <= w_read_data;
      r_read_vld   <= w_read_vld;
      r_parity_err <= w_parity_err;
      r_frame_err  <= w_frame_err;
    end
  end

  always_ff @(posedge clk) begin
    r_rx_sr  <= w_rx_sr;
    r_rx_par <= w_rx_par;
  end

  always_comb begin
    w_rx_state   = r_rx_state;
    w_rx_clk     = r_rx_clk;
    w_rx_bit     = r_rx_bit;
    w_rx_sr      = r_rx_sr;
    w_rx_par     = r_rx_par;
    w_read_data  = r_read_data;
    w_read_vld   = 1'b0;
    w_parity_err = r_parity_err;
    w_frame_err  = r_frame_err;
    case (r_rx_state)
      RX_IDLE: begin
        if (!w_rx) begin
          w_rx_state = RX_START;
          w_rx_clk   = K_HALF;
        end
      end
      RX_WAIT_HIGH: begin
        if (w_rx) w_rx_state = RX_IDLE;
      end
      default: begin
        if (!w_rx_tick) begin
          w_rx_clk = r_rx_clk - KW'(1);
        end else begin
          w_rx_clk = K_LAST;
          case (r_rx_state)
            RX_START: begin
              if (w_rx) begin
                w_rx_state = RX_IDLE;
              end else begin
                w_rx_state = RX_DATA;
                w_rx_bit   = '0;
              end
            end
            RX_DATA: begin
              w_rx_sr = {w_rx, r_rx_sr[DATA_W-1:1]};
              if (r_rx_bit == B_LAST) begin
                if (PARITY != 0) w_rx_state = RX_PAR;
                else             w_rx_state = RX_STOP;
              end else begin
                w_rx_bit = r_rx_bit + BW'(1);
              end
            end
            RX_PAR: begin
              w_rx_par   = w_rx;
              w_rx_state = RX_STOP;
            end
            default: begin
              w_read_data  = r_rx_sr;
              w_read_vld   = 1'b1;
              w_parity_err = (PARITY != 0) && (f_par_bit(r_rx_sr) != r_rx_par);
              w_frame_err  = !w_rx;
              if (w_rx) w_rx_state = RX_IDLE;
              else      w_rx_state = RX_WAIT_HIGH;
            end
          endcase
        end
      end
    endcase
  end
endmodule

// File: tb/tb_uart_multi_xcvr.sv
// Bench for uart_multi_xcvr: frame-level TX/RX model plus directed frames, a default build
// (8 data bits, odd parity) and a 7-bit no-parity build run in loopback.
module tb_uart_multi_xcvr;
  localparam int DW  = 8;
  localparam int NB  = 2;
  localparam int CPB = 16;
  localparam int PAR = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n   = 1'b0;
  logic [NB*DW-1:0] cmd_in = '0;
  logic          cmd_vld = 1'b0;
  logic          cmd_rdy, tx, rx, read_vld, parity_err, frame_err;
  logic [DW-1:0] read_data;
  logic          rx_drv  = 1'b1;
  logic          loop    = 1'b0;
  assign rx = loop ? tx : rx_drv;

  logic [13:0] cmd7_in  = '0;
  logic        cmd7_vld = 1'b0;
  logic        cmd7_rdy, tx7, vld7, perr7, ferr7;
  logic [6:0]  rd7;

  uart_multi_xcvr #(.DATA_W(DW), .NBYTES(NB), .CLKS_PER_BIT(CPB), .PARITY(PAR)) u_dut (
    .clk(clk), .rst_n(rst_n), .cmd_in(cmd_in), .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy),
    .tx(tx), .rx(rx), .read_data(read_data), .read_vld(read_vld),
    .parity_err(parity_err), .frame_err(frame_err)
  );

  uart_multi_xcvr #(.DATA_W(7), .NBYTES(2), .CLKS_PER_BIT(16), .PARITY(0)) u_dut7 (
    .clk(clk), .rst_n(rst_n), .cmd_in(cmd7_in), .cmd_vld(cmd7_vld), .cmd_rdy(cmd7_rdy),
    .tx(tx7), .rx(tx7), .read_data(rd7), .read_vld(vld7),
    .parity_err(perr7), .frame_err(ferr7)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %0h required %0h", name, act, exp);
  endtask

  // Parity bit from the count of ones in the character.
  function automatic logic par_of(input int ones);
    if (PAR == 1) return (ones % 2) == 0;
    else          return (ones % 2) == 1;
  endfunction

  // TX model: one queue entry per expected clock cycle of the tx line.
  logic m_q[$];
  logic m_tx  = 1'b1;
  logic m_rdy = 1'b1;

  function automatic void push_bit(input logic b);
    for (int k = 0; k < CPB; k++) m_q.push_back(b);
  endfunction

  function automatic void push_frames(input logic [NB*DW-1:0] w);
    logic [DW-1:0] ch;
    for (int c = NB - 1; c >= 0; c--) begin
      ch = w[c*DW +: DW];
      push_bit(1'b0);
      for (int i = 0; i < DW; i++) push_bit(ch[i]);
      if (PAR != 0) push_bit(par_of($countones(ch)));
      push_bit(1'b1);
    end
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      m_tx  = 1'b1;
      m_rdy = 1'b1;
    end else if (m_rdy) begin
      if (cmd_vld) begin
        push_frames(cmd_in);
        m_tx  = m_q.pop_front();
        m_rdy = 1'b0;
      end
    end else if (m_q.size() != 0) begin
      m_tx = m_q.pop_front();
    end else begin
      m_tx  = 1'b1;
      m_rdy = 1'b1;
    end
  end

  // Expected receive results: {frame_err, parity_err, data}.
  logic [9:0] rxq[$];
  logic [8:0] rxq7[$];
  logic [7:0] rx_log[$];
  logic [6:0] rx_log7[$];

  always @(negedge clk) begin : cmp
    logic [9:0] e;
    logic [8:0] e7;
    chk("tx", 32'(tx), 32'(m_tx));
    chk("cmd_rdy", 32'(cmd_rdy), 32'(m_rdy));
    if (read_vld) begin
      chk("strobe_expected", 32'(rxq.size() != 0), 32'd1);
      if (rxq.size() != 0) begin
        e = rxq.pop_front();
        chk("read_data", 32'(read_data), 32'(e[7:0]));
        chk("parity_err", 32'(parity_err), 32'(e[8]));
        chk("frame_err", 32'(frame_err), 32'(e[9]));
      end
      rx_log.push_back(read_data);
    end
    if (vld7) begin
      chk("strobe7_expected", 32'(rxq7.size() != 0), 32'd1);
      if (rxq7.size() != 0) begin
        e7 = rxq7.pop_front();
        chk("read_data7", 32'(rd7), 32'(e7[6:0]));
        chk("parity_err7", 32'(perr7), 32'(e7[7]));
        chk("frame_err7", 32'(ferr7), 32'(e7[8]));
      end
      rx_log7.push_back(rd7);
    end
  end

  task automatic drive_bit(input logic b);
    rx_drv = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic bad_par, input logic stop);
    logic p;
    p = par_of($countones(d));
    if (bad_par) p = ~p;
    rxq.push_back({~stop, bad_par && (PAR != 0), d});
    drive_bit(1'b0);
    for (int i = 0; i < DW; i++) drive_bit(d[i]);
    if (PAR != 0) drive_bit(p);
    drive_bit(stop);
  endtask

  task automatic pulse_cmd(input logic [NB*DW-1:0] w);
    @(negedge clk);
    cmd_in  = w;
    cmd_vld = 1'b1;
    @(negedge clk);
    cmd_vld = 1'b0;
  endtask

  task automatic wait_rdy(output int low);
    low = 0;
    while (!cmd_rdy && low < 2000) begin
      low++;
      @(negedge clk);
    end
    chk("tx_done_in_budget", 32'(cmd_rdy), 32'd1);
  endtask

  int offs[8] = '{8, 24, 40, 152, 168, 184, 200, 328};
  int vals[8] = '{0, 1, 0, 1, 1, 0, 0, 1};

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int lowcnt;
    int base;
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_cmd_rdy", 32'(cmd_rdy), 32'd1);
    chk("rst_read_vld", 32'(read_vld), 32'd0);
    chk("rst_parity_err", 32'(parity_err), 32'd0);
    chk("rst_frame_err", 32'(frame_err), 32'd0);
    chk("rst_read_data", 32'(read_data), 32'd0);
    chk("rst_tx7", 32'(tx7), 32'd1);
    #2 rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Two-character transmit with literal bit positions
    pulse_cmd(16'hA53C);
    lowcnt = 0;
    while (cmd_rdy == 1'b0 && lowcnt < 2000) begin
      for (int k = 0; k < 8; k++)
        if (lowcnt == offs[k]) chk("tx_bit_literal", 32'(tx), 32'(vals[k]));
      lowcnt++;
      @(negedge clk);
    end
    chk("rdy_low_cycles", 32'(lowcnt), 32'd352);
    repeat (10) @(negedge clk);

    // Command offered while busy is ignored
    pulse_cmd(16'h1234);
    repeat (50) @(negedge clk);
    cmd_in  = 16'hFFFF;
    cmd_vld = 1'b1;
    @(negedge clk);
    cmd_vld = 1'b0;
    wait_rdy(lowcnt);
    chk("ignored_cmd_low_cycles", 32'(lowcnt + 51), 32'd352);
    repeat (20) @(negedge clk);

    // Loopback 00 then FF
    loop = 1'b1;
    base = rx_log.size();
    rxq.push_back({2'b00, 8'h00});
    rxq.push_back({2'b00, 8'hFF});
    pulse_cmd(16'h00FF);
    wait_rdy(lowcnt);
    chk("loop_rdy_low", 32'(lowcnt), 32'd352);
    repeat (40) @(negedge clk);
    loop = 1'b0;
    chk("loop_pending", 32'(rxq.size()), 32'd0);
    chk("loop_strobes", 32'(rx_log.size() - base), 32'd2);
    if (rx_log.size() >= base + 2) begin
      chk("loop_char0", 32'(rx_log[base]), 32'h00);
      chk("loop_char1", 32'(rx_log[base+1]), 32'hFF);
    end

    // Wrong parity, then a good frame clears the flag
    send_frame(8'h55, 1'b1, 1'b1);
    repeat (20) @(negedge clk);
    chk("bad_par_data", 32'(read_data), 32'h55);
    chk("bad_par_held", 32'(parity_err), 32'd1);
    send_frame(8'hA3, 1'b0, 1'b1);
    repeat (20) @(negedge clk);
    chk("good_par_clear", 32'(parity_err), 32'd0);
    chk("par_pending", 32'(rxq.size()), 32'd0);

    // Stop bit low, line held low 40 more cycles
    base = rx_log.size();
    send_frame(8'h0F, 1'b0, 1'b0);
    repeat (40) @(negedge clk);
    chk("frame_err_held", 32'(frame_err), 32'd1);
    chk("frame_err_one_strobe", 32'(rx_log.size() - base), 32'd1);
    rx_drv = 1'b1;
    repeat (20) @(negedge clk);
    send_frame(8'hC6, 1'b0, 1'b1);
    repeat (20) @(negedge clk);
    chk("frame_err_clear", 32'(frame_err), 32'd0);
    chk("frame_pending", 32'(rxq.size()), 32'd0);

    // Three-cycle glitch produces nothing
    base = rx_log.size();
    rx_drv = 1'b0;
    repeat (3) @(negedge clk);
    rx_drv = 1'b1;
    repeat (40) @(negedge clk);
    chk("glitch_no_strobe", 32'(rx_log.size() - base), 32'd0);

    // Reset mid-transmit with tx looped to rx
    loop = 1'b1;
    base = rx_log.size();
    pulse_cmd(16'hA53C);
    repeat (99) @(negedge clk);
    #2 rst_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("in_rst_tx", 32'(tx), 32'd1);
      chk("in_rst_rdy", 32'(cmd_rdy), 32'd1);
    end
    #2 rst_n = 1'b1;
    repeat (30) begin
      @(negedge clk);
      chk("post_rst_tx", 32'(tx), 32'd1);
      chk("post_rst_rdy", 32'(cmd_rdy), 32'd1);
    end
    chk("rst_no_partial_strobe", 32'(rx_log.size() - base), 32'd0);
    rxq.push_back({2'b00, 8'h5A});
    rxq.push_back({2'b00, 8'h01});
    pulse_cmd(16'h5A01);
    wait_rdy(lowcnt);
    repeat (40) @(negedge clk);
    loop = 1'b0;
    chk("post_rst_pending", 32'(rxq.size()), 32'd0);

    // 7-bit, no-parity build: 9-bit frames in loopback
    base = rx_log7.size();
    rxq7.push_back({2'b00, 7'h00});
    rxq7.push_back({2'b00, 7'h7F});
    @(negedge clk);
    cmd7_in  = 14'h007F;
    cmd7_vld = 1'b1;
    @(negedge clk);
    cmd7_vld = 1'b0;
    lowcnt = 0;
    while (!cmd7_rdy && lowcnt < 2000) begin
      lowcnt++;
      @(negedge clk);
    end
    chk("dw7_rdy_low_cycles", 32'(lowcnt), 32'd288);
    repeat (40) @(negedge clk);
    chk("dw7_pending", 32'(rxq7.size()), 32'd0);
    chk("dw7_strobes", 32'(rx_log7.size() - base), 32'd2);
    if (rx_log7.size() >= base + 2) begin
      chk("dw7_char0", 32'(rx_log7[base]), 32'h00);
      chk("dw7_char1", 32'(rx_log7[base+1]), 32'h7F);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
